// File: rtl/wrr_arb_tree.sv
// Weighted round-robin arbiter with packet awareness.
//
// Each input owns a programmable weight: the number of consecutive packets it
// may win before the turn passes on. Once a multi-beat packet has started, the
// arbiter stays on that input until the beat flagged last_i transfers. With
// LockIn set, a decision presented while the output is stalled is frozen
// until it transfers.
//
// Ports:
//   clk_i, rst_ni   clock (rising edge), asynchronous active-low reset
//   flush_i         synchronous clear of all arbiter state
//   weight_i        per-input weight, NumIn x WeightWidth packed; 0 disables
//   req_i, gnt_o    input-side valid / grant (grant is one-hot or zero)
//   data_i, last_i  input payload and end-of-packet flag
//   req_o, gnt_i    output-side valid / ready
//   data_o, last_o  selected payload and end-of-packet flag
//   idx_o           index of the selected input
module wrr_arb_tree #(
  parameter int unsigned NumIn       = 4,
  parameter int unsigned DataWidth   = 32,
  parameter type         DataType    = logic [DataWidth-1:0],
  parameter int unsigned WeightWidth = 4,
  parameter bit          LockIn      = 1'b1,
  parameter int unsigned IdxWidth    = $clog2(NumIn)
) (
  input  logic                         clk_i,
  input  logic                         rst_ni,
  input  logic                         flush_i,
  input  logic [NumIn*WeightWidth-1:0] weight_i,
  input  logic [NumIn-1:0]             req_i,
  output logic [NumIn-1:0]             gnt_o,
  input  DataType                      data_i [NumIn],
  input  logic [NumIn-1:0]             last_i,
  output logic                         req_o,
  input  logic                         gnt_i,
  output DataType                      data_o,
  output logic                         last_o,
  output logic [IdxWidth-1:0]          idx_o
);

  if (NumIn < 2) begin : g_bad_numin
    $fatal(1, "wrr_arb_tree: NumIn must be >= 2");
  end

  // Which rule produced the current selection, in priority order.
  typedef enum logic [1:0] {
    SelLock = 2'd0,  // frozen by an earlier stall
    SelPkt  = 2'd1,  // continuing a packet already in flight
    SelKeep = 2'd2,  // owner still has credit
    SelNext = 2'd3   // cyclic search after the owner
  } sel_mode_e;

  logic [IdxWidth-1:0]    owner_q, owner_d;
  logic [WeightWidth-1:0] credit_q, credit_d;
  logic                   pkt_q, pkt_d;
  logic                   lock_q, lock_d;
  logic [IdxWidth-1:0]    lidx_q, lidx_d;

  logic [WeightWidth-1:0] weight [NumIn];
  logic [NumIn-1:0]       elig;
  logic [IdxWidth-1:0]    search_idx;
  logic                   found;
  int unsigned            cand;
  logic [IdxWidth-1:0]    sel;
  sel_mode_e              mode;
  logic                   xfer;
  logic                   keep_turn;

  always_comb begin
    for (int unsigned i = 0; i < NumIn; i++) begin
      weight[i] = weight_i[i*WeightWidth +: WeightWidth];
      elig[i]   = req_i[i] & (weight_i[i*WeightWidth +: WeightWidth] != '0);
    end
  end

  // Cyclic search starting just after the owner; the owner itself is the
  // final candidate, so a lone eligible owner keeps winning without a bubble.
  always_comb begin
    found      = 1'b0;
    search_idx = owner_q;
    cand       = 0;
    for (int unsigned off = 1; off <= NumIn; off++) begin
      cand = 32'(owner_q) + off;
      if (cand >= NumIn) cand = cand - NumIn;
      if (!found && elig[IdxWidth'(cand)]) begin
        found      = 1'b1;
        search_idx = IdxWidth'(cand);
      end
    end
  end

  always_comb begin
    mode = SelNext;
    sel  = search_idx;
    if (lock_q) begin
      mode = SelLock;
      sel  = lidx_q;
    end else if (pkt_q) begin
      mode = SelPkt;
      sel  = owner_q;
    end else if (elig[owner_q] && (credit_q != '0)) begin
      mode = SelKeep;
      sel  = owner_q;
    end
  end

  always_comb begin
    req_o  = (mode == SelLock || mode == SelPkt) ? req_i[sel] : (|elig);
    gnt_o  = '0;
    idx_o  = '0;
    data_o = '0;
    last_o = 1'b0;
    if (req_o) begin
      gnt_o[sel] = gnt_i;
      idx_o      = sel;
      data_o     = data_i[sel];
      last_o     = last_i[sel];
    end
  end

  assign xfer = req_o & gnt_i;

  // A frozen decision at packet start was either a credit spend on the owner
  // or a hand-over; owner/credit cannot have moved while it was frozen, so
  // the original rule is recovered from the held index and remaining credit.
  assign keep_turn = (mode == SelKeep) ||
                     ((mode == SelLock) && (lidx_q == owner_q) && (credit_q != '0));

  always_comb begin
    owner_d  = owner_q;
    credit_d = credit_q;
    pkt_d    = pkt_q;
    lock_d   = LockIn & req_o & ~gnt_i;
    lidx_d   = sel;
    if (xfer) begin
      pkt_d = ~last_i[sel];
      if (!pkt_q) begin
        if (keep_turn) begin
          credit_d = credit_q - WeightWidth'(1);
        end else begin
          owner_d  = sel;
          credit_d = (weight[sel] == '0) ? '0 : weight[sel] - WeightWidth'(1);
        end
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      owner_q  <= IdxWidth'(NumIn - 1);
      credit_q <= '0;
      pkt_q    <= 1'b0;
      lock_q   <= 1'b0;
      lidx_q   <= '0;
    end else if (flush_i) begin
      owner_q  <= IdxWidth'(NumIn - 1);
      credit_q <= '0;
      pkt_q    <= 1'b0;
      lock_q   <= 1'b0;
      lidx_q   <= '0;
    end else begin
      owner_q  <= owner_d;
      credit_q <= credit_d;
      pkt_q    <= pkt_d;
      lock_q   <= lock_d;
      lidx_q   <= lidx_d;
    end
  end

  a_gnt_onehot: assert property (@(posedge clk_i) disable iff (!rst_ni)
    $onehot0(gnt_o));
  a_gnt_needs_ready: assert property (@(posedge clk_i) disable iff (!rst_ni)
    (|gnt_o) |-> gnt_i);
  a_gnt_matches_idx: assert property (@(posedge clk_i) disable iff (!rst_ni)
    (req_o && gnt_i) |-> gnt_o[idx_o]);

  if (LockIn) begin : g_lock_checks
    a_idx_stable: assert property (@(posedge clk_i) disable iff (!rst_ni)
      (req_o && !gnt_i && !flush_i) |=> (idx_o == $past(idx_o)));
    a_held_req: assert property (@(posedge clk_i) disable iff (!rst_ni)
      (lock_q && !flush_i) |-> req_i[lidx_q]);
  end

endmodule

// File: tb/tb_wrr_arb_tree.sv
// Directed bench for wrr_arb_tree with default parameters (4 inputs,
// 32-bit data, 4-bit weights, LockIn=1).
module tb_wrr_arb_tree;

  logic        clk_i = 1'b0;
  logic        rst_ni = 1'b0;
  logic        flush_i = 1'b0;
  logic [15:0] weight_i = 16'h1111;
  logic [3:0]  req_i = 4'h0;
  logic [3:0]  gnt_o;
  logic [31:0] data_i [4];
  logic [3:0]  last_i = 4'h0;
  logic        req_o;
  logic        gnt_i = 1'b0;
  logic [31:0] data_o;
  logic        last_o;
  logic [1:0]  idx_o;

  int total = 0;
  int bad   = 0;

  int exp1 [10] = '{0, 0, 0, 1, 2, 2, 3, 0, 0, 0};
  int exp2 [6]  = '{0, 2, 3, 0, 2, 3};

  wrr_arb_tree dut (
    .clk_i    (clk_i),
    .rst_ni   (rst_ni),
    .flush_i  (flush_i),
    .weight_i (weight_i),
    .req_i    (req_i),
    .gnt_o    (gnt_o),
    .data_i   (data_i),
    .last_i   (last_i),
    .req_o    (req_o),
    .gnt_i    (gnt_i),
    .data_o   (data_o),
    .last_o   (last_o),
    .idx_o    (idx_o)
  );

  always #5 clk_i = ~clk_i;

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic drive(input logic [3:0] req, input logic [3:0] last, input logic g);
    req_i  = req;
    last_i = last;
    gnt_i  = g;
    #2;
  endtask

  task automatic do_flush();
    req_i   = 4'h0;
    gnt_i   = 1'b0;
    flush_i = 1'b1;
    tick();
    flush_i = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 4; i++) data_i[i] = 32'hD000_0000 + i;

    // reset state with no requests
    #2;
    chk("rst_req_o", 32'(req_o), 0);
    chk("rst_gnt_o", 32'(gnt_o), 0);
    chk("rst_idx_o", 32'(idx_o), 0);
    chk("rst_data_o", data_o, 0);
    chk("rst_last_o", 32'(last_o), 0);
    #10 rst_ni = 1'b1;
    tick();
    chk("idle_req_o", 32'(req_o), 0);
    chk("idle_data_o", data_o, 0);

    // weights {3,1,2,1}, everyone requesting single-beat packets
    weight_i = 16'h1213;
    for (int k = 0; k < 10; k++) begin
      drive(4'hF, 4'hF, 1'b1);
      chk("t1_idx", 32'(idx_o), exp1[k]);
      chk("t1_gnt", 32'(gnt_o), 32'(1 << exp1[k]));
      chk("t1_data", data_o, 32'hD000_0000 + exp1[k]);
      tick();
    end

    // weights {1,0,1,1}: input 1 disabled
    do_flush();
    weight_i = 16'h1101;
    for (int k = 0; k < 6; k++) begin
      drive(4'hF, 4'hF, 1'b1);
      chk("t2_idx", 32'(idx_o), exp2[k]);
      chk("t2_gnt", 32'(gnt_o), 32'(1 << exp2[k]));
      tick();
    end

    // 3-beat packet on input 0 with a req drop on beat 2
    do_flush();
    weight_i = 16'h1111;
    drive(4'b0011, 4'b0010, 1'b1);
    chk("t3_b1_idx", 32'(idx_o), 0);
    chk("t3_b1_last", 32'(last_o), 0);
    chk("t3_b1_gnt", 32'(gnt_o), 32'h1);
    tick();
    drive(4'b0010, 4'b0010, 1'b1);
    chk("t3_drop_req_o", 32'(req_o), 0);
    chk("t3_drop_gnt", 32'(gnt_o), 0);
    chk("t3_drop_data", data_o, 0);
    tick();
    drive(4'b0010, 4'b0010, 1'b1);
    chk("t3_drop2_req_o", 32'(req_o), 0);
    chk("t3_drop2_gnt", 32'(gnt_o), 0);
    tick();
    drive(4'b0011, 4'b0010, 1'b1);
    chk("t3_b2_idx", 32'(idx_o), 0);
    chk("t3_b2_gnt", 32'(gnt_o), 32'h1);
    chk("t3_b2_last", 32'(last_o), 0);
    tick();
    drive(4'b0011, 4'b0011, 1'b1);
    chk("t3_b3_idx", 32'(idx_o), 0);
    chk("t3_b3_last", 32'(last_o), 1);
    tick();
    drive(4'b0011, 4'b0011, 1'b1);
    chk("t3_next_idx", 32'(idx_o), 1);
    chk("t3_next_gnt", 32'(gnt_o), 32'h2);
    chk("t3_next_data", data_o, 32'hD000_0001);
    tick();

    // decision frozen under backpressure
    do_flush();
    drive(4'b0100, 4'hF, 1'b0);
    chk("t4_s1_req_o", 32'(req_o), 1);
    chk("t4_s1_idx", 32'(idx_o), 2);
    chk("t4_s1_gnt", 32'(gnt_o), 0);
    tick();
    drive(4'b0100, 4'hF, 1'b0);
    chk("t4_s2_idx", 32'(idx_o), 2);
    tick();
    drive(4'b0101, 4'hF, 1'b0);
    chk("t4_s3_idx", 32'(idx_o), 2);
    chk("t4_s3_gnt", 32'(gnt_o), 0);
    tick();
    drive(4'b0101, 4'hF, 1'b1);
    chk("t4_go_idx", 32'(idx_o), 2);
    chk("t4_go_gnt", 32'(gnt_o), 32'h4);
    tick();
    drive(4'b0101, 4'hF, 1'b1);
    chk("t4_after_idx", 32'(idx_o), 0);
    chk("t4_after_gnt", 32'(gnt_o), 32'h1);
    tick();

    // flush while input 2 is mid-packet; weight 2 on input 0
    do_flush();
    weight_i = 16'h1112;
    drive(4'b0100, 4'b1011, 1'b1);
    chk("t5_start_idx", 32'(idx_o), 2);
    tick();
    flush_i = 1'b1;
    drive(4'b0101, 4'hF, 1'b0);
    chk("t5_mid_idx", 32'(idx_o), 2);
    tick();
    flush_i = 1'b0;
    drive(4'b0101, 4'hF, 1'b1);
    chk("t5_f1_idx", 32'(idx_o), 0);
    tick();
    drive(4'b0101, 4'hF, 1'b1);
    chk("t5_f2_idx", 32'(idx_o), 0);
    tick();
    drive(4'b0101, 4'hF, 1'b1);
    chk("t5_f3_idx", 32'(idx_o), 2);
    tick();

    // lone requester through credit exhaustion and reload
    do_flush();
    weight_i = 16'h2111;
    for (int k = 0; k < 6; k++) begin
      drive(4'b1000, 4'hF, 1'b1);
      chk("t6_req_o", 32'(req_o), 1);
      chk("t6_idx", 32'(idx_o), 3);
      chk("t6_gnt", 32'(gnt_o), 32'h8);
      tick();
    end

    req_i = 4'h0;
    gnt_i = 1'b0;
    #2;
    chk("end_req_o", 32'(req_o), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/wrr_arb_tree.md
Name: wrr_arb_tree

Overview:
Weighted round-robin arbiter with packet awareness. It is the successor to the plain round-robin arbitration tree. Each input has a runtime-programmable weight, the number of consecutive packets it may win per turn, and a granted multi-beat packet holds the arbiter until its last beat. It sits in front of shared ports (memory, interconnect masters) where inputs need unequal bandwidth shares and packets must stay intact.

Parameters:
NumIn, 4, number of inputs; must be >= 2 (elaboration-time $fatal otherwise).
DataWidth, 32, payload width in bits.
DataType, logic [DataWidth-1:0], payload type; may be overridden.
WeightWidth, 4, width of each per-input weight.
LockIn, 1'b1, freeze the arbitration decision while the output is stalled.
IdxWidth, $clog2(NumIn), derived; do not override.

Ports:
clk_i  in  1  clock, rising edge.
rst_ni  in  1  asynchronous reset, active low.
flush_i  in  1  synchronous clear of all arbiter state.
weight_i  in  NumIn*WeightWidth  per-input weight; 0 = input disabled.
req_i  in  NumIn  input valid.
gnt_o  out  NumIn  input grant, one-hot or zero.
data_i  in  NumIn x DataType  input payload.
last_i  in  NumIn  input beat is the last beat of its packet.
req_o  out  1  output valid.
gnt_i  in  1  output ready.
data_o  out  DataType  selected payload.
last_o  out  1  last flag of the selected beat.
idx_o  out  IdxWidth  selected input index.

Behaviour:
- Registered state:
  - owner_q (IdxWidth), reset/flush value NumIn-1.
  - credit_q (WeightWidth), reset/flush value 0.
  - pkt_q: mid-packet flag.
  - lock_q / lidx_q: LockIn hold flag and held index.
  - All state is cleared by rst_ni (async) or flush_i (sync, dominates all other updates).
- Eligibility: elig[i] = req_i[i] & (weight_i[i] != 0).
- Selection (combinational, zero-cycle req->req_o), in priority order:
  1. lock_q=1 -> sel = lidx_q.
  2. pkt_q=1 -> sel = owner_q.
  3. elig[owner_q] and credit_q != 0 -> sel = owner_q.
  4. Otherwise, sel = first eligible index after owner_q, searching cyclically; owner_q itself is checked last.
- req_o:
  - In cases 1 and 2: req_o = req_i[sel]. Other inputs are never granted, even if the owner deasserts mid-packet.
  - In cases 3 and 4: req_o = |elig.
- Outputs:
  - When req_o=1: idx_o = sel, data_o = data_i[sel], last_o = last_i[sel].
  - When req_o=0: idx_o = 0, data_o = '0, last_o = 0.
  - gnt_o[sel] = gnt_i & req_o; all other bits 0.
  - With req_i=0 after reset, every output is 0.
- Handshake: a beat transfers when req_o & gnt_i.
- State update on transfer:
  - Packet start (pkt_q=0), case 3 -> credit_d = credit_q-1.
  - Packet start (pkt_q=0), case 4 -> owner_d = sel, credit_d = weight_i[sel]-1.
  - Inside a packet (pkt_q=1) -> credit unchanged.
  - pkt_d = ~last_i[sel] in all cases.
  - No transfer -> owner, credit and pkt hold.
- LockIn=1:
  - lock_d = req_o & ~gnt_i; lidx_d = sel.
  - The held input must keep req asserted; this is enforced by an assertion.
- LockIn=0: lock_q is tied to 0, so selection may change under backpressure.
- Weight changes take effect only at the next credit reload. credit_q is never reloaded mid-turn.
- Weight 0 on the current owner: that input stops winning new packets, but an in-flight packet still completes.
- Wrap-around: searching from owner NumIn-1 starts at index 0.
- Required assertions:
  - gnt_o one-hot or zero.
  - |gnt_o implies gnt_i.
  - req_o & gnt_i implies gnt_o[idx_o].
  - idx_o stable while req_o & ~gnt_i (LockIn=1).

Test Plan:
- NumIn=4, weights {3,1,2,1}, all req, last=1, gnt_i=1 -> idx_o sequence 0,0,0,1,2,2,3,0,0,0.
- Weights {1,0,1,1}, all req, last=1 -> input 1 never granted; idx_o 0,2,3,0,2,3.
- Input 0 sends a 3-beat packet (last on beat 3), input 1 requesting, weights 1 -> idx_o=0 for 3 transfers, then 1. Input 0 dropping req on beat 2 -> req_o=0 and gnt_o=0 until it returns.
- LockIn=1: only input 2 requesting, gnt_i=0 for 2 cycles, then input 0 raises req -> idx_o stays 2 until gnt_i=1; the next grant goes to 0.
- Flush mid-packet (owner 2, pkt_q=1), inputs 0 and 2 requesting -> the next cycle selects 0 with credit reloaded from weight_i[0].
- Only input 3 requesting, weight 2, last=1 -> granted every cycle through credit exhaustion and reload, with no bubble.
